// File: rtl/uc_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : uc_arbiter_if
// Description : Handshake bundle around the unit-clause arbiter: BCP engine
//               offers/grants, the decision-unit init offer, and the GST-facing
//               presentation/pop signals.
// Revision    : 1.0  initial release
// ============================================================================
interface uc_arbiter_if #(
    parameter int NUM_ENGINE = 4,
    parameter int LIT_W      = 8
);
    logic [NUM_ENGINE*LIT_W-1:0] bcp2ucarb_lit;
    logic [NUM_ENGINE-1:0]       bcp2ucarb_valid;
    logic [NUM_ENGINE-1:0]       ucarb2bcp_grant;
    logic [LIT_W-1:0]            dec2ucarb_init_lit;
    logic                        dec2ucarb_init_valid;
    logic                        ucarb2dec_init_ready;
    logic [LIT_W-1:0]            ucarb2gst_lit;
    logic                        ucarb2gst_valid;
    logic [LIT_W-1:0]            ucarb2gst_init_lit;
    logic                        ucarb2gst_init_vaild;
    logic                        gst2ucarb_pop;

    // Environment side: engines, decision unit and GST
    modport master (
        output bcp2ucarb_lit, bcp2ucarb_valid, dec2ucarb_init_lit,
               dec2ucarb_init_valid, gst2ucarb_pop,
        input  ucarb2bcp_grant, ucarb2dec_init_ready, ucarb2gst_lit,
               ucarb2gst_valid, ucarb2gst_init_lit, ucarb2gst_init_vaild
    );

    // Arbiter side
    modport slave (
        input  bcp2ucarb_lit, bcp2ucarb_valid, dec2ucarb_init_lit,
               dec2ucarb_init_valid, gst2ucarb_pop,
        output ucarb2bcp_grant, ucarb2dec_init_ready, ucarb2gst_lit,
               ucarb2gst_valid, ucarb2gst_init_lit, ucarb2gst_init_vaild
    );
endinterface
`default_nettype wire

// File: rtl/uc_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : uc_arbiter
// Description : Unit-clause arbiter ahead of the global state table. A
//               round-robin arbiter serialises engine literals into a FIFO;
//               a held init literal takes presentation priority over the FIFO.
//               Optional macro UCARB_DEDUP_EN drops duplicate literals and
//               flags opposite-polarity clashes on the sticky conflict output.
// Revision    : 1.0  initial release
// ============================================================================
module uc_arbiter #(
    parameter int NUM_ENGINE = 4,
    parameter int LIT_W      = 8,
    parameter int DEPTH      = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     flush,
    uc_arbiter_if.slave              bus,
    output logic                     ucarb_empty,
    output logic                     ucarb_full,
    output logic [$clog2(DEPTH):0]   ucarb_count,
    output logic                     ucarb_conflict
);
    localparam int c_PTR_W = $clog2(DEPTH);
    localparam int c_CNT_W = c_PTR_W + 1;
    localparam int c_RR_W  = (NUM_ENGINE > 1) ? $clog2(NUM_ENGINE) : 1;

    logic [LIT_W-1:0]      r_mem [DEPTH];
    logic [c_PTR_W-1:0]    r_head;
    logic [c_PTR_W-1:0]    r_tail;
    logic [c_CNT_W-1:0]    r_count;
    logic [c_RR_W-1:0]     r_rr;
    logic                  r_init_valid;
    logic [LIT_W-1:0]      r_init_lit;

    logic                  w_fifo_empty;
    logic                  w_full;
    logic [NUM_ENGINE-1:0] w_grant;
    logic                  w_gnt_any;
    logic [c_RR_W-1:0]     w_gnt_idx;
    logic [LIT_W-1:0]      w_gnt_lit;
    logic                  w_init_acc;
    logic                  w_push;
    logic                  w_pop_fifo;
    logic                  w_pop_init;
    logic                  w_gnt_drop;
    logic                  w_init_drop;

    assign w_fifo_empty = (r_count == '0);
    assign w_full       = (r_count == c_CNT_W'(DEPTH));

    // Round-robin search from r_rr; full, flush and reset suppress any grant
    always_comb begin
        int v_idx;
        v_idx     = 0;
        w_grant   = '0;
        w_gnt_any = 1'b0;
        w_gnt_idx = '0;
        if (rst_n && !flush && !w_full) begin
            for (int k = 0; k < NUM_ENGINE; k++) begin
                v_idx = (int'(r_rr) + k) % NUM_ENGINE;
                if (!w_gnt_any && bus.bcp2ucarb_valid[v_idx]) begin
                    w_gnt_any       = 1'b1;
                    w_gnt_idx       = c_RR_W'(v_idx);
                    w_grant[v_idx]  = 1'b1;
                end
            end
        end
    end

    assign w_gnt_lit  = bus.bcp2ucarb_lit[int'(w_gnt_idx)*LIT_W +: LIT_W];
    assign w_init_acc = bus.dec2ucarb_init_valid && !r_init_valid && !flush;
    // A zero literal is granted (consumed) but never written to the FIFO
    assign w_push     = w_gnt_any && (w_gnt_lit != '0) && !w_gnt_drop;
    // Init has presentation priority, so a pop retires it before the FIFO head
    assign w_pop_init = bus.gst2ucarb_pop && r_init_valid;
    assign w_pop_fifo = bus.gst2ucarb_pop && !r_init_valid && !w_fifo_empty;

`ifdef UCARB_DEDUP_EN
    logic             r_conflict;
    logic [DEPTH-1:0] w_ent_valid;
    logic             w_gnt_dup;
    logic             w_gnt_conf;
    logic             w_init_dup;
    logic             w_init_conf;

    // Variable index: negative literals hold the two's complement in the low bits
    function automatic logic [LIT_W-2:0] f_var(input logic [LIT_W-1:0] lit);
        f_var = lit[LIT_W-1] ? (~lit[LIT_W-2:0] + (LIT_W-1)'(1)) : lit[LIT_W-2:0];
    endfunction

    // Mark FIFO slots that currently hold live entries (between head and head+count)
    always_comb begin
        logic [c_PTR_W-1:0] v_off;
        v_off       = '0;
        w_ent_valid = '0;
        for (int i = 0; i < DEPTH; i++) begin
            v_off          = c_PTR_W'(i) - r_head;
            w_ent_valid[i] = ({1'b0, v_off} < r_count);
        end
    end

    // Compare both candidates against live FIFO entries and the held init literal
    always_comb begin
        w_gnt_dup   = 1'b0;
        w_gnt_conf  = 1'b0;
        w_init_dup  = 1'b0;
        w_init_conf = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (w_ent_valid[i]) begin
                if (r_mem[i] == w_gnt_lit)
                    w_gnt_dup = 1'b1;
                else if (f_var(r_mem[i]) == f_var(w_gnt_lit))
                    w_gnt_conf = 1'b1;
                if (r_mem[i] == bus.dec2ucarb_init_lit)
                    w_init_dup = 1'b1;
                else if (f_var(r_mem[i]) == f_var(bus.dec2ucarb_init_lit))
                    w_init_conf = 1'b1;
            end
        end
        if (r_init_valid) begin
            if (r_init_lit == w_gnt_lit)
                w_gnt_dup = 1'b1;
            else if (f_var(r_init_lit) == f_var(w_gnt_lit))
                w_gnt_conf = 1'b1;
        end
    end

    assign w_gnt_drop  = w_gnt_dup | w_gnt_conf;
    assign w_init_drop = w_init_dup | w_init_conf;

    // Sticky conflict flag, cleared only by flush or reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_conflict <= 1'b0;
        else if (flush)
            r_conflict <= 1'b0;
        else if ((w_gnt_any && (w_gnt_lit != '0) && w_gnt_conf) ||
                 (w_init_acc && w_init_conf))
            r_conflict <= 1'b1;
    end

    assign ucarb_conflict = r_conflict;
`else
    assign w_gnt_drop     = 1'b0;
    assign w_init_drop    = 1'b0;
    assign ucarb_conflict = 1'b0;
`endif

    // FIFO storage; no reset needed since pointers/count qualify every read
    always_ff @(posedge clk) begin
        if (w_push)
            r_mem[r_tail] <= w_gnt_lit;
    end

    // Pointers, occupancy, rr pointer and init register; flush wins over all
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_head       <= '0;
            r_tail       <= '0;
            r_count      <= '0;
            r_rr         <= '0;
            r_init_valid <= 1'b0;
            r_init_lit   <= '0;
        end else if (flush) begin
            r_head       <= '0;
            r_tail       <= '0;
            r_count      <= '0;
            r_rr         <= '0;
            r_init_valid <= 1'b0;
            r_init_lit   <= '0;
        end else begin
            if (w_push)
                r_tail <= r_tail + c_PTR_W'(1);
            if (w_pop_fifo)
                r_head <= r_head + c_PTR_W'(1);
            case ({w_push, w_pop_fifo})
                2'b10:   r_count <= r_count + c_CNT_W'(1);
                2'b01:   r_count <= r_count - c_CNT_W'(1);
                default: r_count <= r_count;
            endcase
            if (w_gnt_any) begin
                if (int'(w_gnt_idx) == NUM_ENGINE - 1)
                    r_rr <= '0;
                else
                    r_rr <= w_gnt_idx + c_RR_W'(1);
            end
            if (w_pop_init) begin
                r_init_valid <= 1'b0;
            end else if (w_init_acc && !w_init_drop) begin
                r_init_valid <= 1'b1;
                r_init_lit   <= bus.dec2ucarb_init_lit;
            end
        end
    end

    assign bus.ucarb2bcp_grant      = w_grant;
    assign bus.ucarb2dec_init_ready = !r_init_valid;
    assign bus.ucarb2gst_valid      = !r_init_valid && !w_fifo_empty;
    assign bus.ucarb2gst_lit        = (!r_init_valid && !w_fifo_empty) ? r_mem[r_head] : '0;
    assign bus.ucarb2gst_init_vaild = r_init_valid;
    assign bus.ucarb2gst_init_lit   = r_init_valid ? r_init_lit : '0;

    assign ucarb_empty = w_fifo_empty && !r_init_valid;
    assign ucarb_full  = w_full;
    assign ucarb_count = r_count;

endmodule
`default_nettype wire

// File: tb/tb_uc_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_uc_arbiter
// Description : Scoreboard bench for uc_arbiter. A queue-based reference model
//               predicts each cycle's outputs; a monitor compares them.
// Revision    : 1.0  initial release
// ============================================================================
module tb_uc_arbiter;
    localparam int NE = 4;
    localparam int LW = 8;
    localparam int DP = 16;
    localparam int CW = $clog2(DP) + 1;

    logic clk = 1'b0;
    logic rst_n;
    logic flush;
    logic ucarb_empty, ucarb_full, ucarb_conflict;
    logic [CW-1:0] ucarb_count;

    always #5 clk = ~clk;

    uc_arbiter_if #(.NUM_ENGINE(NE), .LIT_W(LW)) bus ();

    uc_arbiter #(.NUM_ENGINE(NE), .LIT_W(LW), .DEPTH(DP)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .flush          (flush),
        .bus            (bus.slave),
        .ucarb_empty    (ucarb_empty),
        .ucarb_full     (ucarb_full),
        .ucarb_count    (ucarb_count),
        .ucarb_conflict (ucarb_conflict)
    );

    typedef struct {
        int            cyc;
        logic [NE-1:0] grant;
        logic          ready;
        logic          gv;
        logic [LW-1:0] glit;
        logic          iv;
        logic [LW-1:0] ilit;
        int            count;
        logic          empty;
        logic          full;
        logic          conf;
    } exp_t;

    exp_t exp_q[$];
    int   n_vec = 0;
    int   n_err = 0;
    int   cyc   = 0;

    // Reference model state
    logic [LW-1:0] m_q[$];
    logic          m_iv;
    logic [LW-1:0] m_il;
    int            m_rr;
    logic          m_conf;
    int            g_last;
    logic          i_acc_last;

    // Stimulus state
    logic [NE-1:0] eng_v;
    logic [LW-1:0] eng_l [NE];
    logic          ini_v;
    logic [LW-1:0] ini_l;
    int            nv = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s cycle %0d: got %0h expected %0h", nm, cyc, act, exp);
        end
    endtask

    function automatic int var_of(input logic [LW-1:0] l);
        int low;
        low = int'(l[LW-2:0]);
        if (l[LW-1]) return ((1 << (LW-1)) - low) % (1 << (LW-1));
        return low;
    endfunction

`ifdef UCARB_DEDUP_EN
    // 0 = new, bit0 = identical literal held, bit1 = opposite polarity held
    function automatic int classify(input logic [LW-1:0] c);
        int r;
        r = 0;
        foreach (m_q[i]) begin
            if (m_q[i] == c) r |= 1;
            else if (var_of(m_q[i]) == var_of(c) && m_q[i][LW-1] != c[LW-1]) r |= 2;
        end
        if (m_iv) begin
            if (m_il == c) r |= 1;
            else if (var_of(m_il) == var_of(c) && m_il[LW-1] != c[LW-1]) r |= 2;
        end
        return r;
    endfunction
`endif

    function automatic logic [LW-1:0] rand_lit();
        int v;
        logic [LW-1:0] r;
        v = int'($urandom_range(0, 12));
        r = LW'(v);
        if ($urandom_range(0, 1) == 1) r = {1'b1, (LW-1)'((1 << (LW-1)) - v)};
        return r;
    endfunction

    function automatic logic [LW-1:0] next_lit();
        nv = nv % 100 + 1;
        return LW'(nv);
    endfunction

    task automatic model_reset();
        m_q.delete();
        m_iv   = 1'b0;
        m_il   = '0;
        m_rr   = 0;
        m_conf = 1'b0;
    endtask

    // Drive one cycle, record the expected outputs, advance the model
    task automatic cycle(input logic [NE-1:0] v, input logic [NE*LW-1:0] l,
                         input logic iv_in, input logic [LW-1:0] il_in,
                         input logic pop, input logic fl);
        exp_t e;
        int g;
        logic [LW-1:0] gl;
        logic push_g, push_i;
        @(negedge clk);
        bus.bcp2ucarb_valid      = v;
        bus.bcp2ucarb_lit        = l;
        bus.dec2ucarb_init_valid = iv_in;
        bus.dec2ucarb_init_lit   = il_in;
        bus.gst2ucarb_pop        = pop;
        flush                    = fl;
        cyc++;
        g = -1;
        if (m_q.size() < DP && !fl)
            for (int k = 0; k < NE; k++) begin
                int eng;
                eng = (m_rr + k) % NE;
                if (g < 0 && v[eng]) g = eng;
            end
        e.cyc   = cyc;
        e.grant = '0;
        if (g >= 0) e.grant[g] = 1'b1;
        e.ready = !m_iv;
        e.gv    = !m_iv && m_q.size() > 0;
        e.glit  = e.gv ? m_q[0] : '0;
        e.iv    = m_iv;
        e.ilit  = m_il;
        e.count = m_q.size();
        e.empty = m_q.size() == 0 && !m_iv;
        e.full  = m_q.size() == DP;
        e.conf  = m_conf;
        exp_q.push_back(e);
        g_last     = g;
        i_acc_last = iv_in && !m_iv && !fl;
        if (fl) begin
            model_reset();
        end else begin
            push_g = 1'b0;
            push_i = 1'b0;
            gl     = '0;
            if (g >= 0) begin
                gl     = l[g*LW +: LW];
                m_rr   = (g + 1) % NE;
                push_g = (gl != '0);
`ifdef UCARB_DEDUP_EN
                if (push_g && classify(gl) != 0) begin
                    push_g = 1'b0;
                    if ((classify(gl) & 2) != 0) m_conf = 1'b1;
                end
`endif
            end
            if (i_acc_last) begin
                push_i = 1'b1;
`ifdef UCARB_DEDUP_EN
                if (classify(il_in) != 0) begin
                    push_i = 1'b0;
                    if ((classify(il_in) & 2) != 0) m_conf = 1'b1;
                end
`endif
            end
            if (pop) begin
                if (m_iv) m_iv = 1'b0;
                else if (m_q.size() > 0) void'(m_q.pop_front());
            end
            if (push_g) m_q.push_back(gl);
            if (push_i) begin
                m_iv = 1'b1;
                m_il = il_in;
            end
        end
    endtask

    // Engines and decision unit hold their offer until it is taken
    task automatic step(input int p_offer, input int p_init, input bit rnd,
                        input logic pop, input logic fl);
        logic [NE*LW-1:0] pl;
        for (int j = 0; j < NE; j++)
            if (!eng_v[j] && $urandom_range(0, 99) < p_offer) begin
                eng_v[j] = 1'b1;
                eng_l[j] = rnd ? rand_lit() : next_lit();
            end
        if (!ini_v && $urandom_range(0, 99) < p_init) begin
            ini_v = 1'b1;
            ini_l = rand_lit();
        end
        for (int j = 0; j < NE; j++) pl[j*LW +: LW] = eng_l[j];
        cycle(eng_v, pl, ini_v, ini_l, pop, fl);
        if (g_last >= 0) eng_v[g_last] = 1'b0;
        if (i_acc_last) ini_v = 1'b0;
    endtask

    task automatic offer0(input logic [LW-1:0] lit);
        eng_v[0] = 1'b1;
        eng_l[0] = lit;
    endtask

    // Monitor: compares whatever the DUT presents against the scoreboard
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #3;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                n_vec++;
                chk("grant", 32'(bus.ucarb2bcp_grant), 32'(e.grant));
                chk("init_ready", 32'(bus.ucarb2dec_init_ready), 32'(e.ready));
                chk("gst_valid", 32'(bus.ucarb2gst_valid), 32'(e.gv));
                if (e.gv) chk("gst_lit", 32'(bus.ucarb2gst_lit), 32'(e.glit));
                chk("init_vaild", 32'(bus.ucarb2gst_init_vaild), 32'(e.iv));
                if (e.iv) chk("init_lit", 32'(bus.ucarb2gst_init_lit), 32'(e.ilit));
                chk("count", 32'(ucarb_count), 32'(e.count));
                chk("empty", 32'(ucarb_empty), 32'(e.empty));
                chk("full", 32'(ucarb_full), 32'(e.full));
                chk("conflict", 32'(ucarb_conflict), 32'(e.conf));
            end
        end
    end

    initial begin
        rst_n = 1'b0;
        flush = 1'b0;
        bus.bcp2ucarb_valid      = '0;
        bus.bcp2ucarb_lit        = '0;
        bus.dec2ucarb_init_valid = 1'b0;
        bus.dec2ucarb_init_lit   = '0;
        bus.gst2ucarb_pop        = 1'b0;
        eng_v = '0;
        for (int j = 0; j < NE; j++) eng_l[j] = '0;
        ini_v = 1'b0;
        ini_l = '0;
        model_reset();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Reset state, then engines 0 and 2 with 03 / FD
        step(0, 0, 0, 1'b0, 1'b0);
        eng_v[0] = 1'b1; eng_l[0] = 8'h03;
        eng_v[2] = 1'b1; eng_l[2] = 8'hFD;
        repeat (3) step(0, 0, 0, 1'b0, 1'b0);
        step(0, 0, 0, 1'b0, 1'b1);

        // All engines busy, pop every cycle: rotation 0,1,2,3,0
        repeat (6) step(100, 0, 0, 1'b1, 1'b0);
        eng_v = '0;
        step(0, 0, 0, 1'b0, 1'b1);

        // Fill to full, then pop while an engine waits
        for (int i = 0; i < DP; i++) begin
            offer0(next_lit());
            step(0, 0, 0, 1'b0, 1'b0);
        end
        offer0(next_lit());
        step(0, 0, 0, 1'b0, 1'b0);
        step(0, 0, 0, 1'b1, 1'b0);
        repeat (2) step(0, 0, 0, 1'b0, 1'b0);
        eng_v = '0;
        step(0, 0, 0, 1'b0, 1'b1);

        // Init priority over FIFO content
        offer0(8'h07);
        repeat (2) step(0, 0, 0, 1'b0, 1'b0);
        ini_v = 1'b1; ini_l = 8'h05;
        repeat (2) step(0, 0, 0, 1'b0, 1'b0);
        repeat (2) step(0, 0, 0, 1'b1, 1'b0);
        repeat (2) step(0, 0, 0, 1'b0, 1'b0);

        // Duplicate / opposite-polarity sequence, then flush
        offer0(8'h04); step(0, 0, 0, 1'b0, 1'b0);
        offer0(8'h04); step(0, 0, 0, 1'b0, 1'b0);
        offer0(8'hFC); step(0, 0, 0, 1'b0, 1'b0);
        step(0, 0, 0, 1'b0, 1'b0);
        step(0, 0, 0, 1'b0, 1'b1);
        step(0, 0, 0, 1'b0, 1'b0);

        // Asynchronous reset mid-burst
        repeat (6) step(80, 20, 1, 1'($urandom_range(0, 1)), 1'b0);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        n_vec++;
        chk("rst_grant", 32'(bus.ucarb2bcp_grant), 32'h0);
        chk("rst_gst_valid", 32'(bus.ucarb2gst_valid), 32'h0);
        chk("rst_gst_lit", 32'(bus.ucarb2gst_lit), 32'h0);
        chk("rst_init_vaild", 32'(bus.ucarb2gst_init_vaild), 32'h0);
        chk("rst_init_lit", 32'(bus.ucarb2gst_init_lit), 32'h0);
        chk("rst_empty", 32'(ucarb_empty), 32'h1);
        chk("rst_full", 32'(ucarb_full), 32'h0);
        chk("rst_count", 32'(ucarb_count), 32'h0);
        chk("rst_conflict", 32'(ucarb_conflict), 32'h0);
        bus.bcp2ucarb_valid      = '0;
        bus.dec2ucarb_init_valid = 1'b0;
        bus.gst2ucarb_pop        = 1'b0;
        eng_v = '0;
        ini_v = 1'b0;
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;

        // Randomised traffic
        for (int i = 0; i < 1500; i++)
            step(40, 10, 1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 59) == 0));

        #10;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/uc_arbiter.md
Name: uc_arbiter

Overview:
- Unit Clause arbiter directly upstream of the global state table (GST).
- Collects unit-clause literals from `NUM_ENGINE` BCP engines, plus the initial decision literal from the decision unit.
- Serialises them through one round-robin arbiter into a FIFO and presents the head to the GST.
- Advances on the GST's pop strobe.

Parameters:
- NUM_ENGINE, 4, number of BCP engines feeding unit clauses.
- LIT_W, 8, literal width: bit LIT_W-1 is polarity (1 = negative); negative literals hold the two's-complement of the variable index in the low bits.
- DEPTH, 16, FIFO entries, power of two, ≥2.

Ports:
- clk  input  1  clock.
- rst_n  input  1  asynchronous active-low reset.
- bcp2ucarb_lit  input  NUM_ENGINE*LIT_W  unit literal per engine; engine j occupies bits [j*LIT_W +: LIT_W].
- bcp2ucarb_valid  input  NUM_ENGINE  engine j offers a literal.
- ucarb2bcp_grant  output  NUM_ENGINE  one-hot; engine j's literal is accepted this cycle.
- dec2ucarb_init_lit  input  LIT_W  initial decision literal.
- dec2ucarb_init_valid  input  1  initial decision offered.
- ucarb2dec_init_ready  output  1  init register empty; offer accepted this cycle.
- ucarb2gst_lit  output  LIT_W  FIFO head literal.
- ucarb2gst_valid  output  1  FIFO head valid.
- ucarb2gst_init_lit  output  LIT_W  held init literal.
- ucarb2gst_init_vaild  output  1  held init literal valid.
- gst2ucarb_pop  input  1  GST consumed the presented literal.
- flush  input  1  synchronous clear on backtrack.
- ucarb_empty  output  1  FIFO empty and no init pending.
- ucarb_full  output  1  FIFO holds DEPTH entries.
- ucarb_count  output  $clog2(DEPTH)+1  FIFO occupancy.
- ucarb_conflict  output  1  sticky conflict flag.

Behaviour:
- Reset (rst_n low, async) clears:
  - FIFO pointers, count 0, init register invalid, rr pointer 0, conflict 0.
  - All grants 0; ucarb2gst_valid 0; ucarb2gst_init_vaild 0; ucarb_empty 1; ucarb_full 0.
  - Literal outputs 0.
- Arbitration:
  - Grant is combinational from bcp2ucarb_valid and the registered rr pointer.
  - Search starts at the rr index; the first valid engine wins.
  - At most one grant per cycle; no grant when ucarb_full=1.
  - On a grant to j, rr ← (j+1) mod NUM_ENGINE; otherwise rr holds.
- Engines must hold valid/lit stable until granted.
- Push: a granted literal is written at the tail on the clock edge.
  - Visible at the head one cycle after grant if the FIFO was empty (no bypass).
  - A granted literal equal to 0 is consumed but not written.
- Full / pop interaction: full is evaluated on the registered count. When full, no grant is issued even if gst2ucarb_pop=1 the same cycle.
- Init path:
  - Init register loads when dec2ucarb_init_valid=1 and the register is empty.
  - ucarb2dec_init_ready = !init_valid_reg.
- Presentation to GST:
  - Init has priority. While init is pending, ucarb2gst_init_vaild=1 and ucarb2gst_valid is forced 0.
  - gst2ucarb_pop then clears the init register only.
  - Otherwise ucarb2gst_valid = !fifo_empty, and pop advances the head pointer.
  - A pop while nothing is presented is ignored.
- Simultaneous push and pop on a non-full FIFO: both happen; count unchanged.
- Pointers wrap modulo DEPTH. Count is one bit wider than the pointers to distinguish full from empty.
- ucarb_empty = fifo_empty & !init_valid_reg.
- Flush (synchronous, beats every other event except reset):
  - Clears FIFO, init register, conflict and rr pointer next edge.
  - No grant and no init accept in the flush cycle.

Optional Feature:
- Macro: UCARB_DEDUP_EN.
- Defined: each candidate literal (granted or init) is compared against all valid FIFO entries and the held init literal.
  - Identical literal: consumed (grant/ready still given) but not stored.
  - Same variable with opposite polarity: consumed, not stored, and ucarb_conflict set; it stays set until flush or reset.
  - Variable compare uses the decoded index: two's-complement the low bits when polarity=1.
- Undefined: no comparison; every nonzero literal is stored; ucarb_conflict tied 0.

Test Plan:
- After reset, engines 0 and 2 valid with 8'h03 and 8'hFD, no pop → grant 0 in cycle 0, grant 2 in cycle 1; head 8'h03 appears in cycle 1; count=2 in cycle 2.
- All 4 engines valid continuously, pop every cycle → grants rotate 0,1,2,3,0; count stays ≤1.
- Push 16 literals with no pop → ucarb_full=1 and grants 0; assert pop with an engine valid → that cycle no grant, count drops to 15; grant issued next cycle.
- Init 8'h05 plus FIFO holding 8'h07 → ucarb2gst_init_vaild=1, ucarb2gst_valid=0; first pop clears init; second pop removes 8'h07; then ucarb_empty=1.
- UCARB_DEDUP_EN defined: push 8'h04, 8'h04, 8'hFC → count=1, ucarb_conflict=1 after the third grant; flush → count=0, conflict=0 next cycle.
- Assert rst_n low mid-burst between clock edges → outputs reach reset values immediately, without waiting for a clock edge.
